// File: rtl/deltasigma_twister.sv
// First-order delta-sigma DAC core with an optional 4-cycle "twister" output shaper.
// The shaper is built only when DSTW_TWISTER_EN is defined; otherwise the output is the plain NRZ stream.
module deltasigma_twister #(
    parameter int BITS = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] data_in,
    input  logic            data_in_en,
    input  logic            next,
    output logic            ds_out,
    output logic            twister_out
);

    logic [BITS-1:0] code;
    logic [BITS-1:0] acc;
    logic [BITS:0]   sum;
    logic            step;

    assign sum = {1'b0, acc} + {1'b0, code};

    always_ff @(posedge clk) begin
        if (rst)             code <= '0;
        else if (data_in_en) code <= data_in;
    end

    // A load coinciding with a step is seen only by the following step.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            ds_out <= 1'b0;
        end else if (step) begin
            {ds_out, acc} <= sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) step <= 1'b0;
        else     step <= next;
    end

`ifdef DSTW_TWISTER_EN
    typedef enum logic {IDLE, SYM} state_t;

    state_t     state, state_nxt;
    logic [1:0] phase, phase_nxt;
    logic [1:0] phase_inc;
    logic       bit_q, bit_nxt;
    logic       tw_nxt;

    assign phase_inc = phase + 2'd1;

    // Phase 0 is always high; a '1' symbol stays high through phase 2.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        bit_nxt   = bit_q;
        tw_nxt    = 1'b0;
        if (next) begin
            state_nxt = SYM;
            phase_nxt = 2'd0;
            bit_nxt   = ds_out;
            tw_nxt    = 1'b1;
        end else begin
            case (state)
                SYM: begin
                    if (phase == 2'd3) begin
                        state_nxt = IDLE;
                    end else begin
                        phase_nxt = phase_inc;
                        tw_nxt    = bit_q && (phase_inc != 2'd3);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= 2'd0;
            bit_q       <= 1'b0;
            twister_out <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            bit_q       <= bit_nxt;
            twister_out <= tw_nxt;
        end
    end
`else
    assign twister_out = ds_out;
`endif

endmodule

// File: tb/tb_deltasigma_twister.sv
// Randomised and directed bench for deltasigma_twister against a symbol-level reference model.
module tb_deltasigma_twister;
    localparam int BITS = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [BITS-1:0] data_in = '0;
    logic            data_in_en = 1'b0;
    logic            next = 1'b0;
    logic            ds_out;
    logic            twister_out;

    always #5 clk = ~clk;

    deltasigma_twister #(.BITS(BITS)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_en(data_in_en),
        .next(next), .ds_out(ds_out), .twister_out(twister_out)
    );

    int total = 0;
    int bad = 0;

    // reference state: integer accumulator and a queue of pending output levels
    int m_code, m_acc, m_ds, exp_tw;
    bit m_step;
    int symq[$];
    int rises, ones;
    logic prev_tw;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit en, input int d, input bit n);
        int old_ds;
        int s;
        @(negedge clk);
        rst = r; data_in_en = en; data_in = d[BITS-1:0]; next = n;
        @(posedge clk);
        if (r) begin
            m_code = 0; m_acc = 0; m_ds = 0; m_step = 0; exp_tw = 0;
            symq.delete();
        end else begin
            old_ds = m_ds;
            if (m_step) begin
                s     = m_acc + m_code;
                m_ds  = s / (1 << BITS);
                m_acc = s % (1 << BITS);
            end
            if (en) m_code = d % (1 << BITS);
`ifdef DSTW_TWISTER_EN
            if (n) symq = '{1, old_ds, old_ds, 0};
            else if (symq.size() > 0) void'(symq.pop_front());
            exp_tw = (symq.size() > 0) ? symq[0] : 0;
`else
            exp_tw = m_ds;
`endif
            m_step = n;
        end
        #1;
        chk("ds_out", {31'b0, ds_out}, m_ds);
        chk("twister_out", {31'b0, twister_out}, exp_tw);
        if (twister_out === 1'b1 && prev_tw === 1'b0) rises++;
        prev_tw = twister_out;
    endtask

    task automatic pulses(input int cnt, input int gap);
        for (int i = 0; i < cnt; i++) begin
            cyc(0, 0, 0, 1);
            for (int j = 1; j < gap; j++) cyc(0, 0, 0, 0);
        end
    endtask

    initial begin
        prev_tw = 1'b0;
        rises = 0;
        ones = 0;

        // reset state
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_ds", {31'b0, ds_out}, 0);
        chk("rst_tw", {31'b0, twister_out}, 0);

        // half scale, gapless symbols
        cyc(0, 1, 'h10, 0);
        pulses(20, 4);

        // zero code: one rise per symbol in shaped mode, none in NRZ mode
        cyc(0, 1, 'h00, 0);
        rises = 0;
        pulses(20, 4);
`ifdef DSTW_TWISTER_EN
        chk("rises_00", rises, 20);
`else
        chk("rises_00", rises, 0);
`endif

        // full scale minus one: 31 ones in 32 steps from a cleared accumulator
        cyc(1, 0, 0, 0);
        cyc(0, 1, 'h1F, 0);
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(0, 0, 0, 1);
            cyc(0, 0, 0, 0);
            cyc(0, 0, 0, 0);
            cyc(0, 0, 0, 0);
            if (ds_out === 1'b1) ones++;
        end
        chk("ones_1f", ones, 31);

        // load in the same cycle as a step: old code used by that step
        cyc(1, 0, 0, 0);
        cyc(0, 1, 'h10, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 'h08, 0);
        cyc(0, 0, 0, 0);
        chk("same_cyc_ds", {31'b0, ds_out}, 0);
        cyc(0, 0, 0, 0);
        pulses(8, 4);

        // reset in symbol phase 2, then clean restart
        cyc(0, 1, 'h1F, 0);
        pulses(3, 4);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("midrst_tw", {31'b0, twister_out}, 0);
        chk("midrst_ds", {31'b0, ds_out}, 0);
        cyc(0, 1, 'h10, 0);
        pulses(6, 4);

        // slow and aborted symbols
        pulses(4, 7);
        pulses(6, 2);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 80) == 0, ($urandom % 5) == 0,
                int'($urandom_range(0, (1 << BITS) - 1)), ($urandom % 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
